// File: rtl/image_buffer_ctrl.sv
// image_buffer_ctrl
// Sequences one image through a simple-dual-port BRAM with a 1-cycle
// registered read. A valid/ready pixel stream is loaded at addresses
// 0..NUM_PIXELS-1. On start, the stored image is replayed in address order as
// a valid/ready stream with zero bubbles. The image stays stored for replay
// until clear.
module image_buffer_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_PIXELS = 784
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  clear,
  input  logic                  start,
  output logic                  bram_write_en,
  output logic [ADDR_WIDTH-1:0] bram_write_addr,
  output logic [DATA_WIDTH-1:0] bram_write_data,
  output logic [ADDR_WIDTH-1:0] bram_read_addr,
  input  logic [DATA_WIDTH-1:0] bram_read_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  image_full,
  output logic                  done
);

  localparam logic [2:0] ST_EMPTY  = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_FULL   = 3'd2;
  localparam logic [2:0] ST_PRIME  = 3'd3;
  localparam logic [2:0] ST_STREAM = 3'd4;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_PIXELS - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  logic [2:0]            state_reg, state_next;
  logic [ADDR_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR_WIDTH-1:0] rd_ptr_reg, rd_ptr_next;
  logic                  in_ready_reg;
  logic                  image_full_reg, image_full_next;
  logic                  done_reg, done_next;

  logic clear_load;
  logic in_fire;
  logic out_fire;
  logic last_pixel;

  // A clear during LOAD blocks the pixel presented in the same cycle.
  assign clear_load = clear && (state_reg == ST_LOAD);
  assign in_ready   = in_ready_reg && !clear_load;
  assign in_fire    = in_valid && in_ready;

  assign bram_write_en   = in_fire;
  assign bram_write_addr = wr_ptr_reg;
  assign bram_write_data = in_data;

  assign out_valid  = (state_reg == ST_STREAM);
  assign last_pixel = (rd_ptr_reg == LAST_ADDR);
  assign out_last   = out_valid && last_pixel;
  assign out_fire   = out_valid && out_ready;
  assign out_data   = bram_read_data;

  // Advance the read address on the same edge as the handshake so the next word
  // arrives with no bubble. During a stall, the address is held, so the BRAM
  // re-reads the same word.
  assign bram_read_addr = (out_fire && !last_pixel) ? (rd_ptr_reg + ADDR_ONE) : rd_ptr_reg;

  assign image_full = image_full_reg;
  assign done       = done_reg;

  // Next-state, pointer and flag updates for the load/replay sequence.
  always_comb begin
    state_next      = state_reg;
    wr_ptr_next     = wr_ptr_reg;
    rd_ptr_next     = rd_ptr_reg;
    image_full_next = image_full_reg;
    done_next       = 1'b0;
    case (state_reg)
      ST_EMPTY, ST_LOAD: begin
        if (clear_load) begin
          state_next      = ST_EMPTY;
          wr_ptr_next     = '0;
          image_full_next = 1'b0;
        end else if (in_fire) begin
          if (wr_ptr_reg == LAST_ADDR) begin
            state_next      = ST_FULL;
            wr_ptr_next     = '0;
            image_full_next = 1'b1;
          end else begin
            state_next  = ST_LOAD;
            wr_ptr_next = wr_ptr_reg + ADDR_ONE;
          end
        end
      end
      ST_FULL: begin
        if (clear) begin
          state_next      = ST_EMPTY;
          wr_ptr_next     = '0;
          image_full_next = 1'b0;
        end else if (start) begin
          state_next  = ST_PRIME;
          rd_ptr_next = '0;
        end
      end
      ST_PRIME: begin
        state_next = ST_STREAM;
      end
      ST_STREAM: begin
        if (out_fire) begin
          if (last_pixel) begin
            state_next  = ST_FULL;
            rd_ptr_next = '0;
            done_next   = 1'b1;
          end else begin
            rd_ptr_next = rd_ptr_reg + ADDR_ONE;
          end
        end
      end
      default: begin
        state_next      = ST_EMPTY;
        wr_ptr_next     = '0;
        rd_ptr_next     = '0;
        image_full_next = 1'b0;
      end
    endcase
  end

  // State registers. in_ready is registered from the next state, so it falls on
  // the edge that accepts the final pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_EMPTY;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      in_ready_reg   <= 1'b0;
      image_full_reg <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      in_ready_reg   <= (state_next == ST_EMPTY) || (state_next == ST_LOAD);
      image_full_reg <= image_full_next;
      done_reg       <= done_next;
    end
  end

endmodule

// File: tb/tb_image_buffer_ctrl.sv
// tb_image_buffer_ctrl
// Scoreboard bench. The stimulus tasks record expected BRAM writes and expected
// output pixels in queues. A negedge monitor pops and compares these entries
// whenever the DUT writes or completes an output handshake. The reference model
// is a plain array holding the image that should currently be stored.
module tb_image_buffer_ctrl;

  localparam int DW = 8;
  localparam int AW = 10;
  localparam int N  = 784;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } px_t;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          clear;
  logic          start;
  logic          bram_write_en;
  logic [AW-1:0] bram_write_addr;
  logic [DW-1:0] bram_write_data;
  logic [AW-1:0] bram_read_addr;
  logic [DW-1:0] bram_read_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          image_full;
  logic          done;

  image_buffer_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_PIXELS(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .clear(clear), .start(start),
    .bram_write_en(bram_write_en), .bram_write_addr(bram_write_addr),
    .bram_write_data(bram_write_data), .bram_read_addr(bram_read_addr),
    .bram_read_data(bram_read_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .image_full(image_full), .done(done)
  );

  // Image BRAM with a registered read port.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bram_write_en) mem[bram_write_addr] <= bram_write_data;
    bram_read_data <= mem[bram_read_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  int wr_cnt     = 0;
  int out_hs_cnt = 0;

  wr_t exp_wr[$];
  px_t exp_out[$];
  logic [DW-1:0] ref_img [N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every write and every output handshake against the
  // scoreboard, and make sure stalled output holds steady.
  logic          stall_prev;
  logic [DW-1:0] stall_data;
  initial begin
    stall_prev = 1'b0;
    stall_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (bram_write_en) begin
          wr_cnt++;
          if (exp_wr.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_write: got write addr %0d data 0x%0h, expected none",
                     bram_write_addr, bram_write_data);
          end else begin
            wr_t w;
            w = exp_wr.pop_front();
            check("write_addr", bram_write_addr, w.addr);
            check("write_data", bram_write_data, w.data);
          end
        end
        if (stall_prev) begin
          check("stall_valid", out_valid, 1);
          check("stall_data", out_data, stall_data);
        end
        if (out_valid && out_ready) begin
          out_hs_cnt++;
          if (exp_out.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_output: got pixel 0x%0h, expected none", out_data);
          end else begin
            px_t p;
            p = exp_out.pop_front();
            check("out_data", out_data, p.data);
            check("out_last", out_last, p.last);
          end
        end
        stall_prev = out_valid && !out_ready;
        stall_data = out_data;
      end
    end
  end

  // Load 'count' pixels. mode 0: addr mod 256, 1: constant 0xA5, 2: random.
  // If start_at >= 0, start is also raised on that pixel.
  task automatic load_image(input int count, input int mode, input int start_at);
    int base;
    int t;
    logic [DW-1:0] d;
    base = wr_cnt;
    for (int k = 0; k < count; k++) begin
      t = 0;
      while (!in_ready && t < 50) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
        t++;
      end
      if (!in_ready) begin
        vectors++;
        miscompares++;
        $display("FAIL load_timeout: got in_ready 0 at pixel %0d, expected 1", k);
        break;
      end
      case (mode)
        0:       d = DW'(k % 256);
        1:       d = 8'hA5;
        default: d = DW'($urandom_range(0, 255));
      endcase
      ref_img[k] = d;
      exp_wr.push_back({AW'(k), d});
      in_valid = 1'b1;
      in_data  = d;
      start    = (k == start_at);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check("load_write_count", wr_cnt - base, count);
    if (count == N) begin
      check("load_in_ready_low", in_ready, 0);
      check("load_image_full", image_full, 1);
      check("load_no_out_valid", out_valid, 0);
    end
  endtask

  // Replay the stored image, with out_ready either always high or random. In
  // random mode, the bench stalls at least once on the last pixel.
  task automatic stream_image(input bit rand_ready);
    int  cyc;
    bit  stalled_last;
    for (int i = 0; i < N; i++) exp_out.push_back({(i == N - 1), ref_img[i]});
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("prime_no_valid", out_valid, 0);
    @(posedge clk); #1;
    check("first_valid", out_valid, 1);
    cyc = 0;
    stalled_last = 1'b0;
    while (exp_out.size() > 0 && cyc < 8 * N) begin
      if (rand_ready) begin
        out_ready = ($urandom_range(0, 3) != 0);
        if (out_valid && out_last && !stalled_last) begin
          out_ready    = 1'b0;
          stalled_last = 1'b1;
        end
      end else begin
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (exp_out.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL stream_timeout: got %0d pixels missing, expected 0", exp_out.size());
      exp_out.delete();
    end
    if (!rand_ready) check("stream_cycles", cyc, N);
    check("done_pulse", done, 1);
    check("end_out_valid", out_valid, 0);
    check("end_image_full", image_full, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("idle_out_valid", out_valid, 0);
  endtask

  initial begin
    int t;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = '0;
    clear     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;

    // Reset values while reset is held.
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_image_full", image_full, 0);
    check("rst_done", done, 0);
    check("rst_write_en", bram_write_en, 0);
    check("rst_read_addr", bram_read_addr, 0);
    #10;
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk); #1;
    check("rel_in_ready", in_ready, 1);

    // Full load, then a full-rate replay, then a replay with backpressure.
    load_image(N, 0, -1);
    stream_image(1'b0);
    stream_image(1'b1);

    // Clear a stored image, partially load, abort the load, then reload with
    // 0xA5.
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("clear_full_image_full", image_full, 0);
    check("clear_full_in_ready", in_ready, 1);
    load_image(300, 0, -1);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h3C;
    #1;
    check("clear_blocks_write", bram_write_en, 0);
    check("clear_gates_in_ready", in_ready, 0);
    @(posedge clk); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clear_load_image_full", image_full, 0);
    check("clear_load_in_ready", in_ready, 1);
    load_image(N, 1, -1);
    stream_image(1'b1);

    // When clear and start arrive together in FULL, clear takes priority.
    clear = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    start = 1'b0;
    check("clr_start_image_full", image_full, 0);
    check("clr_start_in_ready", in_ready, 1);
    check("clr_start_no_valid", out_valid, 0);
    @(posedge clk); #1;
    check("clr_start_no_valid2", out_valid, 0);

    // Start is ignored during LOAD. The monitor flags any out_valid here.
    load_image(N, 2, 100);
    stream_image(1'b0);

    // Apply an asynchronous reset mid-stream after 400 output pixels.
    for (int i = 0; i < N; i++) exp_out.push_back({(i == N - 1), ref_img[i]});
    out_hs_cnt = 0;
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t = 0;
    while (out_hs_cnt < 400 && t < 4 * N) begin
      @(posedge clk); #1;
      t++;
    end
    check("rst_mid_progress", out_hs_cnt, 400);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_image_full", image_full, 0);
    check("arst_done", done, 0);
    check("arst_in_ready", in_ready, 0);
    exp_out.delete();
    exp_wr.delete();
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst_rel_in_ready", in_ready, 1);
    check("arst_rel_out_valid", out_valid, 0);

    // The controller recovers: load and replay a fresh random image.
    load_image(N, 2, -1);
    stream_image(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
